// File: rtl/td4_pkg.sv
// -----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 program loader:
//   - default memory geometry and idle timeout
//   - program word type
//   - loader state encoding
//   - checksum helper used when TD4_LOADER_CHECKSUM_EN is defined
// -----------------------------------------------------------------------------
package td4_pkg;

    localparam int TD4_DEPTH   = 16;
    localparam int TD4_WIDTH   = 8;
    localparam int TD4_AW      = $clog2(TD4_DEPTH);
    localparam int TD4_TIMEOUT = 1000000;

    typedef logic [TD4_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    // A good image sums (program bytes + checksum byte) to zero modulo 256.
    function automatic logic checksum_ok(input word_t sum, input word_t csum);
        word_t total;
        total = sum + csum;
        return (total == word_t'(0));
    endfunction

endpackage

// File: rtl/td4_prog_ram.sv
// -----------------------------------------------------------------------------
// td4_prog_ram
// DEPTH x WIDTH program memory: one synchronous write port, one asynchronous
// read port, asynchronous clear-to-zero on reset. A read of the address being
// written in the same cycle returns the old word (write lands at the edge).
// Ports:
//   clock  in  1      write clock
//   reset  in  1      async active-high, zeroes every word
//   we     in  1      write enable
//   waddr  in  AW     write address
//   wdata  in  WIDTH  write data
//   raddr  in  AW     read address
//   rdata  out WIDTH  mem[raddr], combinational
// -----------------------------------------------------------------------------
module td4_prog_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array: cleared on reset, written on enabled clock edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// -----------------------------------------------------------------------------
// td4_prog_loader
// Owns the TD4 program memory, fills it from a byte stream and holds the core
// in reset (cpu_run=0) until a complete image has been loaded.
// Optional feature macro: TD4_LOADER_CHECKSUM_EN -- after DEPTH program bytes
// one extra checksum byte is expected; the image is accepted only if all
// bytes plus the checksum sum to zero modulo 256.
// Ports:
//   clock       in   1       single clock, posedge
//   reset       in   1       async active-high, clears all state and memory
//   load_req    in   1       start/restart a load (beats every other input)
//   run_req     in   1       release core without loading (IDLE only)
//   rx_data     in   WIDTH   incoming program byte
//   rx_valid    in   1       rx_data valid
//   rx_ready    out  1       loader accepts a byte this cycle
//   fetch_addr  in   AW      core instruction pointer
//   fetch_data  out  WIDTH   mem[fetch_addr], combinational
//   cpu_run     out  1       1 = core runs (core active-low reset)
//   busy        out  1       1 while loading / checking
//   error       out  1       1 in ERROR
//   load_count  out  AW+1    words written in current/last load
// -----------------------------------------------------------------------------
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int DEPTH          = TD4_DEPTH,
    parameter int WIDTH          = TD4_WIDTH,
    parameter int TIMEOUT_CYCLES = TD4_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_req,
    input  logic                     run_req,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic [$clog2(DEPTH)-1:0] fetch_addr,
    output logic [WIDTH-1:0]         fetch_data,
    output logic                     cpu_run,
    output logic                     busy,
    output logic                     error,
    output logic [$clog2(DEPTH):0]   load_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    // Timer value at which one more idle cycle expires the timeout.
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [AW:0]   CNT_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    loader_state_t   state_r;
    loader_state_t   state_s;
    logic [AW:0]     cnt_r;
    logic [TW-1:0]   timer_r;
    logic            cpu_run_r;
    logic            busy_r;
    logic            error_r;
    logic            in_rx_s;
    logic            xfer_s;
    logic            we_s;
    logic            timeout_s;
`ifdef TD4_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_r;
`endif

    assign in_rx_s   = (state_r == LOAD) || (state_r == CHECK);
    assign rx_ready  = in_rx_s && !load_req;
    assign xfer_s    = rx_valid && rx_ready;
    assign we_s      = xfer_s && (state_r == LOAD);
    assign timeout_s = TIMEOUT_EN && in_rx_s && !xfer_s && (timer_r == TMO_LAST);

    td4_prog_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (we_s),
        .waddr (cnt_r[AW-1:0]),
        .wdata (rx_data),
        .raddr (fetch_addr),
        .rdata (fetch_data)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; load_req overrides every other condition.
    always_comb begin
        state_s = state_r;
        if (load_req) begin
            state_s = LOAD;
        end else begin
            case (state_r)
                IDLE: begin
                    if (run_req) begin
                        state_s = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD: begin
                    if (xfer_s && (cnt_r == CNT_LAST)) begin
`ifdef TD4_LOADER_CHECKSUM_EN
                        state_s = CHECK;
`else
                        state_s = RUN;
`endif
                    end else if (timeout_s) begin
                        state_s = ERROR;
                    end else begin
                        state_s = LOAD;
                    end
                end
                CHECK: begin
`ifdef TD4_LOADER_CHECKSUM_EN
                    if (xfer_s) begin
                        state_s = checksum_ok(sum_r, rx_data) ? RUN : ERROR;
                    end else if (timeout_s) begin
                        state_s = ERROR;
                    end else begin
                        state_s = CHECK;
                    end
`else
                    // Unreachable without the checksum feature; fail safe.
                    state_s = ERROR;
`endif
                end
                RUN: begin
                    state_s = RUN;
                end
                ERROR: begin
                    state_s = ERROR;
                end
                default: begin
                    state_s = ERROR;
                end
            endcase
        end
    end

    // Load counter, idle timer and optional checksum accumulator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r   <= '0;
            timer_r <= '0;
`ifdef TD4_LOADER_CHECKSUM_EN
            sum_r   <= '0;
`endif
        end else if (load_req) begin
            cnt_r   <= '0;
            timer_r <= '0;
`ifdef TD4_LOADER_CHECKSUM_EN
            sum_r   <= '0;
`endif
        end else if (xfer_s) begin
            timer_r <= '0;
            if (state_r == LOAD) begin
                cnt_r <= cnt_r + CNT_ONE;
`ifdef TD4_LOADER_CHECKSUM_EN
                sum_r <= sum_r + rx_data;
`endif
            end
        end else if (in_rx_s && TIMEOUT_EN) begin
            // Leaves LOAD/CHECK on expiry, so the timer cannot overflow.
            timer_r <= timer_r + TMR_ONE;
        end
    end

    // Registered output decode taken from the next state, so outputs follow
    // the state register exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_run_r <= 1'b0;
            busy_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            cpu_run_r <= (state_s == RUN);
            busy_r    <= (state_s == LOAD) || (state_s == CHECK);
            error_r   <= (state_s == ERROR);
        end
    end

    assign cpu_run    = cpu_run_r;
    assign busy       = busy_r;
    assign error      = error_r;
    assign load_count = cnt_r;

endmodule

// File: tb/tb_td4_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_td4_prog_loader
// Directed bench for td4_prog_loader (DEPTH=16, WIDTH=8, TIMEOUT_CYCLES=20).
// The checksum steps are compiled in when TD4_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_td4_prog_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_req;
    logic       run_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       cpu_run;
    logic       busy;
    logic       error;
    logic [4:0] load_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_mem [16];
    logic [7:0] prog    [16];
    logic [7:0] sum;

    always #5 clock = ~clock;

    td4_prog_loader #(
        .DEPTH          (16),
        .WIDTH          (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_req   (load_req),
        .run_req    (run_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .error      (error),
        .load_count (load_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            fetch_addr = 4'(i);
            #1;
            check($sformatf("%s mem[%0d]", tag, i), {24'h0, fetch_data}, {24'h0, exp_mem[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog = '{8'h3C, 8'h36, 8'hB1, 8'h52, 8'hE3, 8'h07, 8'h90, 8'h4A,
                 8'hF0, 8'h11, 8'hB3, 8'h05, 8'h60, 8'hE7, 8'hA2, 8'h01};
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        reset      = 1'b0;
        load_req   = 1'b0;
        run_req    = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        fetch_addr = 4'h0;
        #1 reset = 1'b1;
        repeat (3) tick();
        check("rst busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        tick();
        check("rst cpu_run", {31'h0, cpu_run}, 32'h0);
        check("rst error", {31'h0, error}, 32'h0);
        check("rst load_count", {27'h0, load_count}, 32'h0);
        check("rst rx_ready", {31'h0, rx_ready}, 32'h0);

        // run_req from IDLE
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        check("run cpu_run", {31'h0, cpu_run}, 32'h1);
        check("run busy", {31'h0, busy}, 32'h0);
        check_mem("zero");
        // bytes offered in RUN are not acknowledged
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        #1;
        check("run rx_ready", {31'h0, rx_ready}, 32'h0);
        tick();
        rx_valid = 1'b0;
        check("run ignore count", {27'h0, load_count}, 32'h0);

        // full back-to-back load
        pulse_load();
        check("load cpu_run", {31'h0, cpu_run}, 32'h0);
        check("load busy", {31'h0, busy}, 32'h1);
        check("load count0", {27'h0, load_count}, 32'h0);
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            rx_data  = prog[i];
            rx_valid = 1'b1;
            #1;
            if (i == 0) check("load rx_ready", {31'h0, rx_ready}, 32'h1);
            tick();
            exp_mem[i] = prog[i];
            sum = sum + prog[i];
        end
        rx_valid = 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
        send(8'h00 - sum);
`endif
        check("load count16", {27'h0, load_count}, 32'h10);
        check("load done cpu_run", {31'h0, cpu_run}, 32'h1);
        check("load done busy", {31'h0, busy}, 32'h0);
        check("load done error", {31'h0, error}, 32'h0);
        check_mem("load");
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        #1;
        check("extra rx_ready", {31'h0, rx_ready}, 32'h0);
        tick();
        rx_valid = 1'b0;
        check("extra count", {27'h0, load_count}, 32'h10);
        fetch_addr = 4'h0;
        #1;
        check("extra mem0", {24'h0, fetch_data}, 32'h3C);

        // load with 3-cycle gaps between bytes
        pulse_load();
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            send(prog[i] ^ 8'hFF);
            exp_mem[i] = prog[i] ^ 8'hFF;
            sum = sum + (prog[i] ^ 8'hFF);
            if (i == 7) check("gap count8", {27'h0, load_count}, 32'h8);
            repeat (3) tick();
        end
`ifdef TD4_LOADER_CHECKSUM_EN
        send(8'h00 - sum);
`endif
        check("gap count16", {27'h0, load_count}, 32'h10);
        check("gap cpu_run", {31'h0, cpu_run}, 32'h1);
        check_mem("gap");

        // restart after 7 bytes while rx_valid is high
        pulse_load();
        for (int i = 0; i < 7; i++) begin
            send(8'hA0 + 8'(i));
            exp_mem[i] = 8'hA0 + 8'(i);
        end
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        load_req = 1'b1;
        #1;
        check("restart rx_ready", {31'h0, rx_ready}, 32'h0);
        tick();
        load_req = 1'b0;
        check("restart count0", {27'h0, load_count}, 32'h0);
        check("restart busy", {31'h0, busy}, 32'h1);
        rx_data = 8'h55;
        tick();
        rx_valid = 1'b0;
        exp_mem[0] = 8'h55;
        check("restart count1", {27'h0, load_count}, 32'h1);
        check_mem("restart");

        // idle timeout after 5 bytes
        pulse_load();
        for (int i = 0; i < 5; i++) begin
            send(8'hC0 + 8'(i));
            exp_mem[i] = 8'hC0 + 8'(i);
        end
        repeat (19) tick();
        check("tmo error@19", {31'h0, error}, 32'h0);
        check("tmo busy@19", {31'h0, busy}, 32'h1);
        tick();
        check("tmo error@20", {31'h0, error}, 32'h1);
        check("tmo cpu_run", {31'h0, cpu_run}, 32'h0);
        check("tmo busy", {31'h0, busy}, 32'h0);
        check("tmo count", {27'h0, load_count}, 32'h5);
        check_mem("tmo");
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        check("err run_req cpu_run", {31'h0, cpu_run}, 32'h0);
        check("err run_req error", {31'h0, error}, 32'h1);
        pulse_load();
        check("recover busy", {31'h0, busy}, 32'h1);
        check("recover error", {31'h0, error}, 32'h0);

        // reset in the middle of a load
        for (int i = 0; i < 3; i++) send(8'h11 + 8'(i));
        #2 reset = 1'b1;
        #1;
        check("midrst busy", {31'h0, busy}, 32'h0);
        check("midrst count", {27'h0, load_count}, 32'h0);
        check("midrst rx_ready", {31'h0, rx_ready}, 32'h0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        check_mem("midrst");
        tick();
        reset = 1'b0;
        tick();
        check("midrst cpu_run", {31'h0, cpu_run}, 32'h0);
        check("midrst error", {31'h0, error}, 32'h0);

`ifdef TD4_LOADER_CHECKSUM_EN
        // good checksum
        pulse_load();
        for (int i = 0; i < 16; i++) send(8'h01);
        check("cs check busy", {31'h0, busy}, 32'h1);
        check("cs check count", {27'h0, load_count}, 32'h10);
        check("cs check cpu_run", {31'h0, cpu_run}, 32'h0);
        send(8'hF0);
        check("cs good cpu_run", {31'h0, cpu_run}, 32'h1);
        check("cs good error", {31'h0, error}, 32'h0);
        // bad checksum
        pulse_load();
        for (int i = 0; i < 16; i++) send(8'h01);
        send(8'hF1);
        check("cs bad error", {31'h0, error}, 32'h1);
        check("cs bad cpu_run", {31'h0, cpu_run}, 32'h0);
        pulse_load();
        check("cs recover busy", {31'h0, busy}, 32'h1);
        check("cs recover error", {31'h0, error}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
